// File: rtl/riscv_pkg.sv
// Shared RV32 fetch constants: XLEN, the canonical NOP, instruction alignment
// and the packed {pc, inst} record carried through the fetch buffer.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam int INST_ALIGN_BITS = 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << INST_ALIGN_BITS) - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK) != '0;
    endfunction

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface fetch_unit_if;

    logic                         req_valid;
    logic                         req_ready;
    logic [riscv_pkg::XLEN-1:0]   req_addr;
    logic                         resp_valid;
    logic [riscv_pkg::XLEN-1:0]   resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-2 FIFO with an extra wrap bit on each pointer; a push into a full
// FIFO is taken only when a pop frees the slot in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, in-order imem requests, redirect/discard handling
// and a response FIFO to decode. Define FETCH_BYPASS_EN for a same-cycle response bypass.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    output logic [XLEN-1:0]   inst,
    output logic              inst_valid,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              fetch_fault
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]          pc_q;
    logic [CNT_W-1:0]         outstanding_q;
    logic [CNT_W-1:0]         outstanding_next;
    logic [CNT_W-1:0]         discard_q;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W:0]           in_use;
    logic                     fault_q;
    logic                     req_fire;
    logic                     resp_live;
    logic                     resp_drop;
    logic                     resp_retire;
    logic [XLEN-1:0]          resp_pc;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    fetch_entry_t             fifo_in;
    logic [$bits(fetch_entry_t)-1:0] fifo_head_raw;
    fetch_entry_t             fifo_head;

    assign in_use           = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(fifo_count);
    assign imem.req_valid   = rst_n && !fault_q && !redirect_valid &&
                              (in_use < (CNT_W + 1)'(DEPTH));
    assign imem.req_addr    = pc_q;
    assign req_fire         = imem.req_valid && imem.req_ready;
    assign resp_live        = imem.resp_valid && (discard_q == '0);
    assign resp_drop        = imem.resp_valid && (discard_q != '0);
    assign resp_retire      = imem.resp_valid && (outstanding_q != '0);
    assign outstanding_next = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_retire);

    // Live in-flight requests are consecutive words ending just below pc_q,
    // so the returning response belongs to the oldest of them.
    assign resp_pc     = pc_q - (XLEN'(outstanding_q) << INST_ALIGN_BITS);
    assign fifo_in     = '{pc: resp_pc, inst: imem.resp_data};
    assign fifo_head   = fetch_entry_t'(fifo_head_raw);
    assign fifo_pop    = !fifo_empty && inst_ready && !redirect_valid;
    assign fetch_fault = fault_q;

    always_comb begin
        inst_valid = !fifo_empty;
        inst       = fifo_empty ? NOP_INST : fifo_head.inst;
        inst_pc    = fifo_empty ? '0 : fifo_head.pc;
        fifo_push  = resp_live && !redirect_valid && !fault_q && (!fifo_full || fifo_pop);
`ifdef FETCH_BYPASS_EN
        if (fifo_empty && fifo_push) begin
            inst_valid = 1'b1;
            inst       = imem.resp_data;
            inst_pc    = resp_pc;
            fifo_push  = !inst_ready;
        end
`endif
    end

    // On redirect every request still in flight after this edge is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fault_q       <= 1'b0;
        end else begin
            outstanding_q <= outstanding_next;
            if (redirect_valid) begin
                pc_q      <= align_pc(redirect_pc);
                discard_q <= outstanding_next;
                fault_q   <= is_misaligned(redirect_pc);
            end else begin
                if (req_fire)  pc_q      <= pc_q + XLEN'(4);
                if (resp_drop) discard_q <= discard_q - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head_data (fifo_head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model, instruction scoreboard,
// a redirect vector table and hand-written stall/flush/bypass sequences.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] MAGIC_PC = 32'h0000_0300;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_LATENCY = 1;
`else
    localparam int EXP_LATENCY = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        logic [31:0] rpc;
        logic        exp_fault;
        int          deliver;
        logic [31:0] exp_last_pc;
    } redirect_vec_t;

    redirect_vec_t vecs [7];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          delivered = 0;
    int          fire_count = 0;
    logic [31:0] exp_pc, exp_req_addr, last_pc, hold_addr;
    logic        hold_pending, mem_hold, mem_ready;
    logic [31:0] mem_q [$];
    logic        s_req_valid, s_inst_valid, s_resp_valid, s_fault;
    logic [31:0] s_req_addr, s_inst, s_inst_pc, s_resp_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memData(input logic [31:0] addr);
        if (addr == MAGIC_PC) return 32'hDEAD_BEEF;
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs, sample at negedge, score, then model memory.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic fired;
        inst_ready         = rdy;
        redirect_valid     = redir;
        redirect_pc        = rpc;
        imem_bus.req_ready = mem_ready;
        @(negedge clk);
        s_req_valid  = imem_bus.req_valid;
        s_req_addr   = imem_bus.req_addr;
        s_inst_valid = inst_valid;
        s_inst       = inst;
        s_inst_pc    = inst_pc;
        s_resp_valid = imem_bus.resp_valid;
        s_resp_data  = imem_bus.resp_data;
        s_fault      = fetch_fault;
        fired = s_req_valid && imem_bus.req_ready;
        if (redir) checkBit("req_valid_on_redirect", s_req_valid, 1'b0);
        if (hold_pending && !redir) begin
            checkBit("req_hold_valid", s_req_valid, 1'b1);
            checkOutput("req_hold_addr", s_req_addr, hold_addr);
        end
        hold_pending = s_req_valid && !imem_bus.req_ready;
        hold_addr    = s_req_addr;
        if (fired) begin
            checkOutput("req_addr", s_req_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
            fire_count++;
        end
        if (s_inst_valid && rdy) begin
            checkOutput("inst_pc", s_inst_pc, exp_pc);
            checkOutput("inst", s_inst, memData(exp_pc));
            last_pc = s_inst_pc;
            exp_pc  = exp_pc + 32'd4;
            delivered++;
        end
        if (redir) begin
            exp_pc       = rpc & ~32'h3;
            exp_req_addr = rpc & ~32'h3;
        end
        if (s_resp_valid && mem_q.size() > 0) mem_q.delete(0);
        if (fired) mem_q.push_back(s_req_addr);
        @(posedge clk);
        #1;
        if (!mem_hold && mem_q.size() > 0) begin
            imem_bus.resp_valid = 1'b1;
            imem_bus.resp_data  = memData(mem_q[0]);
        end else begin
            imem_bus.resp_valid = 1'b0;
            imem_bus.resp_data  = 32'd0;
        end
    endtask

    task automatic doReset();
        rst_n               = 1'b0;
        inst_ready          = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'd0;
        imem_bus.resp_valid = 1'b0;
        imem_bus.resp_data  = 32'd0;
        imem_bus.req_ready  = 1'b1;
        mem_q.delete();
        mem_hold     = 1'b0;
        mem_ready    = 1'b1;
        hold_pending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkBit("rst_req_valid", imem_bus.req_valid, 1'b0);
        checkOutput("rst_req_addr", imem_bus.req_addr, 32'd0);
        checkBit("rst_inst_valid", inst_valid, 1'b0);
        checkOutput("rst_inst", inst, 32'h0000_0013);
        checkOutput("rst_inst_pc", inst_pc, 32'd0);
        checkBit("rst_fault", fetch_fault, 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        exp_pc       = 32'd0;
        exp_req_addr = 32'd0;
    endtask

    task automatic runUntilDelivered(input int n, input int budget);
        int start;
        start = delivered;
        for (int i = 0; i < budget && (delivered - start) < n; i++) applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("deliver_count", delivered - start, n);
    endtask

    initial begin
        int first_valid;
        int fc;
        int iv;
        int d0;
        logic found;

        vecs[0] = '{32'h0000_0100, 1'b0, 3, 32'h0000_0108};
        vecs[1] = '{32'h0000_0102, 1'b1, 0, 32'h0000_0000};
        vecs[2] = '{32'h0000_0200, 1'b0, 2, 32'h0000_0204};
        vecs[3] = '{32'h0000_0201, 1'b1, 0, 32'h0000_0000};
        vecs[4] = '{32'h0000_0203, 1'b1, 0, 32'h0000_0000};
        vecs[5] = '{32'hFFFF_FFF8, 1'b0, 3, 32'h0000_0000};
        vecs[6] = '{32'h0000_0040, 1'b0, 2, 32'h0000_0044};

        doReset();

        // Streaming from reset: first request immediately, then in-order delivery.
        first_valid = -1;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            if (c == 0) checkBit("first_req_valid", s_req_valid, 1'b1);
            if (s_inst_valid && first_valid < 0) first_valid = c;
        end
        checkOutput("first_inst_latency", first_valid, EXP_LATENCY);

        // Decode stalled: only DEPTH requests may be issued.
        doReset();
        fire_count = 0;
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("stall_fire_count", fire_count, DEPTH);
        checkBit("stall_req_valid", s_req_valid, 1'b0);
        checkBit("stall_inst_valid", s_inst_valid, 1'b1);
        runUntilDelivered(6, 40);

        // Two requests in flight when redirected: both responses must be dropped.
        doReset();
        mem_hold = 1'b1;
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 32'd0);
        checkOutput("inflight_before_redirect", mem_q.size(), 2);
        applyStimulus(1'b1, 1'b1, 32'h0000_0100);
        mem_hold = 1'b0;
        runUntilDelivered(3, 40);
        checkOutput("stale_drop_last_pc", last_pc, 32'h0000_0108);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(1'b1, 1'b1, vecs[v].rpc);
            if (vecs[v].exp_fault) begin
                fc = fire_count;
                iv = 0;
                for (int c = 0; c < 6; c++) begin
                    applyStimulus(1'b1, 1'b0, 32'd0);
                    if (s_inst_valid) iv++;
                end
                checkBit("vec_fault_set", s_fault, 1'b1);
                checkOutput("vec_fault_no_req", fire_count - fc, 0);
                checkOutput("vec_fault_no_inst", iv, 0);
            end else begin
                runUntilDelivered(vecs[v].deliver, 40);
                checkBit("vec_fault_clear", s_fault, 1'b0);
                checkOutput("vec_last_pc", last_pc, vecs[v].exp_last_pc);
            end
        end

        // FIFO full, pop and redirect together: exactly one instruction consumed.
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, 32'd0);
        checkBit("full_inst_valid", s_inst_valid, 1'b1);
        d0 = delivered;
        applyStimulus(1'b1, 1'b1, 32'h0000_0500);
        checkOutput("redirect_pop_count", delivered - d0, 1);
        runUntilDelivered(2, 40);
        checkOutput("after_flush_last_pc", last_pc, 32'h0000_0504);

        // Memory back-pressure and decode stalls interleaved.
        for (int c = 0; c < 30; c++) begin
            mem_ready = (c % 3 == 2);
            applyStimulus(1'(c % 2), 1'b0, 32'd0);
        end
        mem_ready = 1'b1;
        runUntilDelivered(4, 40);

        // Response into an empty FIFO: bypass timing.
        applyStimulus(1'b1, 1'b1, MAGIC_PC);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            if (s_resp_valid && s_resp_data == 32'hDEAD_BEEF) found = 1'b1;
        end
        checkBit("magic_resp_seen", found, 1'b1);
`ifdef FETCH_BYPASS_EN
        checkBit("bypass_same_valid", s_inst_valid, 1'b1);
        checkOutput("bypass_same_inst", s_inst, 32'hDEAD_BEEF);
`else
        checkBit("nobypass_same_valid", s_inst_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkBit("nobypass_next_valid", s_inst_valid, 1'b1);
        checkOutput("nobypass_next_inst", s_inst, 32'hDEAD_BEEF);
        checkOutput("nobypass_next_pc", s_inst_pc, MAGIC_PC);
`endif

        // Reset while faulted clears everything and fetch restarts at RESET_PC.
        applyStimulus(1'b1, 1'b1, 32'h0000_0123);
        applyStimulus(1'b1, 1'b0, 32'd0);
        checkBit("pre_reset_fault", s_fault, 1'b1);
        doReset();
        runUntilDelivered(2, 40);
        checkOutput("post_reset_last_pc", last_pc, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
